// File: rtl/wb_burst_master.sv
// wb_burst_master: command-driven Wishbone burst master feeding the memory
// controller's slave port. One Wishbone cycle per command with incrementing
// bursts, a one-entry write holding register, a registered read-data stream
// and a stalled-transfer timeout abort.
module wb_burst_master #(
    parameter int AW   = 26,
    parameter int DW   = 32,
    parameter int LW   = 9,
    parameter int TO_W = 8
) (
    input  logic              sys_clk,
    input  logic              resetn,
    input  logic              sdr_init_done,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [LW-1:0]     cmd_len,
    input  logic              cmd_wr,
    input  logic [DW/8-1:0]   cmd_sel,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DW-1:0]     wdata,
    output logic              rdata_valid,
    output logic [DW-1:0]     rdata,
    output logic              rdata_last,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [2:0]        wb_cti_o,
    input  logic [DW-1:0]     wb_dat_i,
    input  logic              wb_ack_i
);
    localparam int SW = DW / 8;
    // Abort fires on the edge that closes the (2^TO_W - 1)th ack-less strobe
    // cycle, i.e. while the counter still shows one less than all-ones.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_FIN} state_t;

    state_t            r_state;
    logic [AW-1:0]     r_addr;
    logic [LW-1:0]     r_len;
    logic [LW-1:0]     r_beat_cnt;
    logic [LW-1:0]     r_acc;
    logic [SW-1:0]     r_sel;
    logic              r_we;
    logic              r_cyc;
    logic              r_stb;      // doubles as the hold-register valid in WR
    logic [DW-1:0]     r_hold;
    logic [2:0]        r_cti;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_err_pend;
    logic              r_done;
    logic              r_err;
    logic              r_rvalid;
    logic              r_rlast;
    logic [DW-1:0]     r_rdata;

    logic w_accept, w_ack, w_last_ack, w_to_hit, w_wfire;

    assign cmd_ready   = (r_state == S_IDLE) && sdr_init_done;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_ack       = r_stb && wb_ack_i;
    assign w_last_ack  = w_ack && (r_beat_cnt == LW'(1));
    // An ack in the terminal cycle wins over the timeout.
    assign w_to_hit    = r_stb && !wb_ack_i && (r_to_cnt == TO_LAST);
    // Refill the holding register in the same cycle it drains: no bubble.
    assign wdata_ready = (r_state == S_WR) && (r_acc < r_len) && (!r_stb || wb_ack_i);
    assign w_wfire     = wdata_valid && wdata_ready;

    // Command FSM: owns the Wishbone cycle, addressing, cti and completion pulses.
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_acc      <= '0;
            r_sel      <= '0;
            r_we       <= 1'b0;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_hold     <= '0;
            r_cti      <= 3'b000;
            r_to_cnt   <= '0;
            r_err_pend <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= cmd_addr;
                        r_len      <= cmd_len;
                        r_beat_cnt <= cmd_len;
                        r_acc      <= '0;
                        r_sel      <= cmd_sel;
                        r_we       <= cmd_wr;
                        r_to_cnt   <= '0;
                        r_err_pend <= 1'b0;
                        if (cmd_len == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state <= cmd_wr ? S_WR : S_RD;
                            r_cyc   <= 1'b1;
                            r_stb   <= !cmd_wr;  // writes wait for the first data beat
                            r_cti   <= (cmd_len == LW'(1)) ? 3'b000 : 3'b010;
                        end
                    end
                end
                S_WR, S_RD: begin
                    if (w_wfire) begin
                        r_hold <= wdata;
                        r_acc  <= r_acc + LW'(1);
                    end
                    if (r_stb && !wb_ack_i) r_to_cnt <= r_to_cnt + TO_W'(1);
                    else                    r_to_cnt <= '0;
                    if (w_ack) begin
                        // Adding a power-of-two lane count never touches the low
                        // address bits, so unaligned offsets pass through.
                        r_addr     <= r_addr + AW'(SW);
                        r_beat_cnt <= r_beat_cnt - LW'(1);
                        if (r_beat_cnt == LW'(2)) r_cti <= 3'b111;
                    end
                    if (w_last_ack) begin
                        r_state <= S_FIN;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_cti   <= 3'b000;
                    end else if (w_to_hit) begin
                        r_state    <= S_FIN;
                        r_cyc      <= 1'b0;
                        r_stb      <= 1'b0;
                        r_cti      <= 3'b000;
                        r_to_cnt   <= '0;
                        r_err_pend <= 1'b1;
                    end else if (r_state == S_WR) begin
                        r_stb <= w_wfire || (r_stb && !wb_ack_i);
                    end
                end
                S_FIN: begin
                    r_done     <= 1'b1;
                    r_err      <= r_err_pend;
                    r_err_pend <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read return path: one-cycle registered copy of each acknowledged beat.
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_ack && (r_state == S_RD);
            r_rlast  <= w_ack && (r_state == S_RD) && (r_beat_cnt == LW'(1));
            if (w_ack && (r_state == S_RD)) r_rdata <= wb_dat_i;
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign err         = r_err;
    assign rdata_valid = r_rvalid;
    assign rdata_last  = r_rlast;
    assign rdata       = r_rdata;
    assign wb_cyc_o    = r_cyc;
    assign wb_stb_o    = r_stb;
    assign wb_we_o     = r_we;
    assign wb_addr_o   = r_addr;
    assign wb_sel_o    = r_sel;
    assign wb_dat_o    = r_hold;
    assign wb_cti_o    = r_cti;
endmodule
